sbox_sequencer: RTL and testbench
=================================

# sbox_sequencer

Time-multiplexed controller for the DES substitution stage. It accepts one 48-bit expanded-and-keyed round value per transaction and steps it through a parameterised number of shared S-box lookup lanes over several cycles. It assembles the eight 4-bit results into the 32-bit S-stage output and hands it on with a valid/ready handshake. It sits between the round-key XOR and the P-permutation in the iterative round datapath, trading latency for S-box area.

## Interface
- LANES, 2, number of S-box lookups performed per cycle; legal values 1, 2, 4, 8; RUN length is 8/LANES cycles
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  in_data holds a valid round value
- in_ready  out  1  sequencer can accept; in_ready = (state==IDLE) | (state==DONE & out_ready)
- in_data  in  48  E-expanded value XOR round key; bits [47:42] feed S1, ..., bits [5:0] feed S8
- out_valid  out  1  out_data holds a complete result
- out_ready  in  1  downstream accepts out_data
- out_data  out  32  S1 result in [31:28], ..., S8 result in [3:0]
- busy  out  1  high in RUN and DONE

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready: capture in_data into a 48-bit operand register, clear the box index idx (3 bits) and the result register, go to RUN.
- RUN: each cycle, lane k (0..LANES-1) looks up box b=idx+k. Input chunk = operand[47-6b -: 6]; row = {chunk[5], chunk[0]}; col = chunk[4:1]. The 4-bit result is written to result[31-4b -: 4]. idx advances by LANES, modulo 8. When idx+LANES==8 the lookup is the last one: go to DONE, assert out_valid. in_data and in_valid are ignored during RUN.
- DONE: out_valid=1; out_data and the result register hold stable until out_ready.
  - out_ready & !in_valid: go to IDLE.
  - out_ready & in_valid: same-cycle handoff. Capture the new operand and go straight to RUN with idx=0.
- The operand register is the only copy of the input, so the upstream value may change after acceptance.
- Reset (any state, including mid-RUN): state=IDLE, idx=0, result=0, out_valid=0, out_data=32'h0, busy=0, in_ready=1. Any partial result is discarded and no out_valid pulse is produced.
- All widths are fixed. idx wraps 7→0 only when leaving RUN.

## Timing
- Accepting edge E0. RUN spans edges E0+1 .. E0+8/LANES. out_valid is high from edge E0+8/LANES onward.
  - LANES=1: 8 cycles. LANES=2: 4. LANES=4: 2. LANES=8: 1.
- Sustained throughput with out_ready held high and in_valid held high: one result every 8/LANES+1 cycles.
- in_ready depends combinationally on out_ready in DONE only. There are no other combinational input-to-output paths.
- out_data is registered and never shows partial results: it updates only when entering DONE.

## Structure
- Package des_pkg holds:
  - the state enum (IDLE/RUN/DONE)
  - constants for S-box count (8), chunk width (6) and nibble width (4)
  - the eight 64-entry S-box tables as a constant array indexed [box][row][col]
- One sub-module, sbox_lut: inputs box_sel[2:0] and in_6bit[5:0], output out_4bit[3:0]. It is combinational and reads the des_pkg tables. The sequencer instantiates LANES copies.
- The sequencer owns the FSM, idx counter, operand register and result register.

## Test plan
- Reset, then in_data=48'h0 with in_valid pulsed → out_data=32'hEFA72C4D, out_valid rising at E0+4 (LANES=2).
- in_data=48'hFFFF_FFFF_FFFF → out_data=32'hD9CE3DCB. Repeat with LANES=1, 4 and 8; out_valid must rise at E0+8, E0+2 and E0+1 respectively.
- Hold out_ready=0 for 10 cycles in DONE → out_valid and out_data stable, in_ready=0. Then raise out_ready together with in_valid → same-cycle handoff, new result after 8/LANES more cycles.
- Assert rst on the second RUN cycle → out_valid stays 0, out_data=0, in_ready=1 the following cycle. A fresh transaction then completes normally.
- Change in_data and toggle in_valid during RUN → result unchanged, no extra accept.
- 1000 random 48-bit values with random out_ready backpressure → every result matches a reference S-stage model in order, with no drops or duplicates.

Source files
------------

// File: rtl/des_pkg.sv
// Shared constants, FSM state type and DES S-box tables for the
// time-multiplexed substitution stage.
package des_pkg;

  localparam int unsigned NUM_BOXES = 8;
  localparam int unsigned CHUNK_W   = 6;
  localparam int unsigned NIBBLE_W  = 4;
  localparam int unsigned IN_W      = NUM_BOXES * CHUNK_W;
  localparam int unsigned OUT_W     = NUM_BOXES * NIBBLE_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Indexed [box][row][col]; box 0 is S1.
  localparam int unsigned SBOX [NUM_BOXES][4][16] = '{
    '{'{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7},
      '{ 0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8},
      '{ 4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0},
      '{15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13}},
    '{'{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10},
      '{ 3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5},
      '{ 0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15},
      '{13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9}},
    '{'{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8},
      '{13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1},
      '{13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7},
      '{ 1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12}},
    '{'{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15},
      '{13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9},
      '{10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4},
      '{ 3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14}},
    '{'{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9},
      '{14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6},
      '{ 4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14},
      '{11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3}},
    '{'{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11},
      '{10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8},
      '{ 9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6},
      '{ 4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13}},
    '{'{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1},
      '{13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6},
      '{ 1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2},
      '{ 6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12}},
    '{'{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7},
      '{ 1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2},
      '{ 7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8},
      '{ 2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}}
  };

endpackage

// File: rtl/sbox_lut.sv
// One combinational DES S-box lookup with a runtime-selectable box.
module sbox_lut
  import des_pkg::*;
(
  input  logic [2:0]          box_sel,
  input  logic [CHUNK_W-1:0]  in_6bit,
  output logic [NIBBLE_W-1:0] out_4bit
);

  logic [1:0] row;
  logic [3:0] col;

  // Outer bits pick the row, inner four bits pick the column.
  always_comb begin
    row      = {in_6bit[5], in_6bit[0]};
    col      = in_6bit[4:1];
    out_4bit = NIBBLE_W'(SBOX[box_sel][row][col]);
  end

endmodule

// File: rtl/sbox_sequencer.sv
// Steps one 48-bit keyed round value through LANES shared S-box lookups
// per cycle and hands the assembled 32-bit S-stage result downstream.
module sbox_sequencer
  import des_pkg::*;
#(
  parameter int unsigned LANES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             busy
);

  state_e state, state_nxt;

  logic [2:0]          idx;
  logic [IN_W-1:0]     operand;
  logic [OUT_W-1:0]    result, result_nxt;
  logic                accept, last;

  logic [2:0]          lane_box   [LANES];
  logic [CHUNK_W-1:0]  lane_chunk [LANES];
  logic [NIBBLE_W-1:0] lane_out   [LANES];

  // DONE releases in the same cycle downstream takes the result.
  assign in_ready  = (state == ST_IDLE) | ((state == ST_DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign last      = (32'(idx) + LANES) == NUM_BOXES;
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);

  always_comb begin
    for (int k = 0; k < int'(LANES); k++) begin
      lane_box[k]   = idx + 3'(k);
      lane_chunk[k] = operand[(NUM_BOXES - 1 - 32'(idx + 3'(k))) * CHUNK_W +: CHUNK_W];
    end
  end

  for (genvar k = 0; k < int'(LANES); k++) begin : g_lane
    sbox_lut u_lut (
      .box_sel  (lane_box[k]),
      .in_6bit  (lane_chunk[k]),
      .out_4bit (lane_out[k])
    );
  end

  always_comb begin
    result_nxt = result;
    for (int k = 0; k < int'(LANES); k++) begin
      result_nxt[(NUM_BOXES - 1 - 32'(lane_box[k])) * NIBBLE_W +: NIBBLE_W] = lane_out[k];
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (accept) state_nxt = ST_RUN;
      ST_RUN:  if (last)   state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = in_valid ? ST_RUN : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // out_data only loads the completed word so partial results never escape.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      operand  <= '0;
      result   <= '0;
      out_data <= '0;
    end else if (accept) begin
      idx      <= '0;
      operand  <= in_data;
      result   <= '0;
    end else if (state == ST_RUN) begin
      idx      <= idx + 3'(LANES);
      result   <= result_nxt;
      if (last) out_data <= result_nxt;
    end
  end

endmodule

// File: tb/tb_sbox_sequencer.sv
// Bench for sbox_sequencer: directed latency/handshake steps on all four
// lane counts plus a randomized backpressure run against an S-stage model.
module tb_sbox_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]  in_valid, in_ready, out_valid, out_ready, busy;
  logic [47:0] in_data  [4];
  logic [31:0] out_data [4];

  // Instance g runs with LANES = 1 << g (1, 2, 4, 8).
  for (genvar g = 0; g < 4; g++) begin : g_dut
    sbox_sequencer #(.LANES(1 << g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .busy      (busy[g])
    );
  end

  // Each box as 64 nibbles, row-major, first entry in the top nibble.
  localparam logic [255:0] SB_REF [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  int checks = 0;
  int errors = 0;
  logic [31:0] expq [$];

  function automatic logic [31:0] ref_sstage(input logic [47:0] x);
    logic [31:0]  r;
    logic [5:0]   ch;
    logic [255:0] tbl;
    int           e;
    r = '0;
    for (int b = 0; b < 8; b++) begin
      ch  = 6'(x >> (42 - 6 * b));
      e   = int'({ch[5], ch[0]}) * 16 + int'(ch[4:1]);
      tbl = SB_REF[b];
      r   = {r[27:0], 4'(tbl >> (252 - 4 * e))};
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [47:0] rnd48();
    return 48'({$urandom(), $urandom()});
  endfunction

  task automatic wait_valid(input int d, output int cnt);
    cnt = 0;
    while (out_valid[d] !== 1'b1 && cnt < 40) begin
      step();
      cnt++;
    end
  endtask

  // Accept one value, optionally jiggle the inputs during RUN, then check
  // latency, data and the return to idle.
  task automatic send_and_check(input int d, input string tag, input logic [47:0] data,
                                input int lat, input bit toggle);
    int cnt;
    in_valid[d]  = 1'b1;
    in_data[d]   = data;
    out_ready[d] = 1'b0;
    #1;
    chk({tag, "_in_ready"}, 64'(in_ready[d]), 64'd1);
    step();
    in_valid[d] = 1'b0;
    in_data[d]  = rnd48();
    cnt = 0;
    while (out_valid[d] !== 1'b1 && cnt < 40) begin
      if (toggle) begin
        in_valid[d] = 1'($urandom_range(1, 0));
        in_data[d]  = rnd48();
      end
      step();
      cnt++;
    end
    in_valid[d] = 1'b0;
    chk({tag, "_latency"}, 64'(cnt), 64'(lat));
    chk({tag, "_data"}, 64'(out_data[d]), 64'(ref_sstage(data)));
    out_ready[d] = 1'b1;
    step();
    out_ready[d] = 1'b0;
    chk({tag, "_idle"}, 64'({out_valid[d], busy[d], in_ready[d]}), 64'(3'b001));
  endtask

  initial begin
    logic [47:0] x, y, z;
    int          cnt;
    int          sent, rcvd, cyc;
    bit          pend;
    logic [47:0] cur;

    rst       = 1'b1;
    in_valid  = '0;
    out_ready = '0;
    for (int d = 0; d < 4; d++) in_data[d] = '0;
    repeat (3) step();
    rst = 1'b0;

    for (int d = 0; d < 4; d++) begin
      chk($sformatf("reset_flags_%0d", d), 64'({out_valid[d], busy[d], in_ready[d]}), 64'(3'b001));
      chk($sformatf("reset_data_%0d", d), 64'(out_data[d]), 64'd0);
    end

    send_and_check(1, "zero", 48'h0, 4, 1'b0);
    chk("zero_const", 64'(ref_sstage(48'h0)), 64'h0000_0000_EFA7_2C4D);
    for (int d = 0; d < 4; d++)
      send_and_check(d, $sformatf("ones_l%0d", 1 << d), 48'hFFFF_FFFF_FFFF, 8 >> d, 1'b0);
    chk("ones_const", 64'(ref_sstage(48'hFFFF_FFFF_FFFF)), 64'h0000_0000_D9CE_3DCB);

    // Backpressure hold followed by a same-cycle handoff.
    x = rnd48();
    y = rnd48();
    in_valid[1] = 1'b1;
    in_data[1]  = x;
    step();
    in_valid[1] = 1'b0;
    wait_valid(1, cnt);
    chk("bp_latency", 64'(cnt), 64'd4);
    repeat (10) begin
      step();
      chk("bp_hold_flags", 64'({out_valid[1], in_ready[1], busy[1]}), 64'(3'b101));
      chk("bp_hold_data", 64'(out_data[1]), 64'(ref_sstage(x)));
    end
    out_ready[1] = 1'b1;
    in_valid[1]  = 1'b1;
    in_data[1]   = y;
    #1;
    chk("handoff_in_ready", 64'(in_ready[1]), 64'd1);
    step();
    in_valid[1]  = 1'b0;
    out_ready[1] = 1'b0;
    in_data[1]   = rnd48();
    chk("handoff_run", 64'({out_valid[1], busy[1]}), 64'(2'b01));
    wait_valid(1, cnt);
    chk("handoff_latency", 64'(cnt), 64'd4);
    chk("handoff_data", 64'(out_data[1]), 64'(ref_sstage(y)));
    out_ready[1] = 1'b1;
    step();
    out_ready[1] = 1'b0;

    // Reset during the second RUN cycle discards the partial result.
    z = rnd48();
    in_valid[1] = 1'b1;
    in_data[1]  = z;
    step();
    in_valid[1] = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_flags", 64'({out_valid[1], in_ready[1], busy[1]}), 64'(3'b010));
    chk("midrst_data", 64'(out_data[1]), 64'd0);
    repeat (6) begin
      step();
      chk("midrst_quiet", 64'({out_valid[1], busy[1]}), 64'd0);
    end
    send_and_check(1, "post_rst", rnd48(), 4, 1'b0);

    send_and_check(1, "run_toggle_l2", rnd48(), 4, 1'b1);
    send_and_check(0, "run_toggle_l1", rnd48(), 8, 1'b1);

    // Random stream with random backpressure, checked in order.
    sent = 0;
    rcvd = 0;
    cyc  = 0;
    pend = 1'b0;
    cur  = '0;
    while (rcvd < 1000 && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      if (!pend && sent < 1000 && $urandom_range(3, 0) != 0) begin
        cur  = rnd48();
        pend = 1'b1;
      end
      in_valid[1]  = pend;
      in_data[1]   = pend ? cur : rnd48();
      out_ready[1] = ($urandom_range(2, 0) != 0);
      #1;
      if (out_valid[1] && out_ready[1]) begin
        if (expq.size() == 0) chk("rnd_extra", 64'(expq.size()), 64'd1);
        else chk("rnd_data", 64'(out_data[1]), 64'(expq.pop_front()));
        rcvd++;
      end
      if (in_valid[1] && in_ready[1]) begin
        expq.push_back(ref_sstage(cur));
        pend = 1'b0;
        sent++;
      end
    end
    @(negedge clk);
    in_valid[1]  = 1'b0;
    out_ready[1] = 1'b0;
    chk("rnd_count", 64'(rcvd), 64'd1000);
    chk("rnd_left", 64'(expq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
